currency_acceptor: RTL
======================

Name: currency_acceptor

Overview:
- Upstream stage of the atp payment controller: validates inserted notes, accumulates them in escrow, and delivers the total to atp over currency_inserted / currency_amount.
- Handles customer cancel, inactivity timeout and revocation by atp by refunding the escrowed notes.
- One instance per payment terminal.

Parameters:
- MAX_TOTAL, 255: largest escrow total accepted; must be ≤ 255.
- MAX_NOTES, 8: maximum number of notes held in escrow.
- TIMEOUT, 1000: idle cycles in COLLECT before an automatic refund.
- HOLD_CYCLES, 2: cycles that currency_inserted stays high during delivery.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- accept_en  in  1  atp is in the currency-payment step
- note_valid  in  1  single-cycle note-inserted strobe
- note_denom  in  3  0:10, 1:20, 2:50, 3:100, 4:200, 5-7:invalid
- confirm  in  1  customer finished inserting
- cancel  in  1  customer abort
- currency_inserted  out  1  delivery strobe to atp
- currency_amount  out  8  escrow total to atp; valid while currency_inserted=1
- note_accept  out  1  one-cycle pulse: note taken
- note_reject  out  1  one-cycle pulse: note returned
- refund_valid  out  1  refund strobe to dispenser
- refund_amount  out  8  value refunded this strobe
- refund_denom  out  3  denomination refunded (feature-dependent)
- busy  out  1  state != IDLE
- note_count  out  4  notes currently in escrow

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; total, note count and timer cleared. Escrow contents are discarded and no refund is issued.
- States: IDLE, COLLECT, DELIVER, REFUND.
- IDLE:
  - accept_en=1 moves to COLLECT on the next edge.
  - note_valid in IDLE produces note_reject one cycle later.
- COLLECT, per-cycle priority: cancel > accept_en=0 > confirm > note_valid > timeout.
  - cancel, or accept_en falling: go to REFUND if total > 0, else IDLE.
  - confirm with total > 0: go to DELIVER. confirm with total = 0 is ignored.
  - note_valid: note_accept or note_reject pulses exactly one cycle after the strobe. Reject if denom ≥ 5, note_count = MAX_NOTES, or total + value > MAX_TOTAL. Otherwise add value to total and increment note_count; the updated values are visible on the same cycle as note_accept.
  - Timer: resets on any note_valid; otherwise increments. When it reaches TIMEOUT, act as cancel.
- DELIVER:
  - currency_inserted=1 and currency_amount=total for exactly HOLD_CYCLES cycles. currency_amount is 0 at all other times.
  - Then total and note_count clear and state returns to IDLE.
  - cancel, confirm and note inputs are ignored (notes rejected).
- REFUND: see Optional Feature. On completion, total and note_count clear and state returns to IDLE. Notes arriving during REFUND are rejected.
- note_accept, note_reject and refund_valid are never high simultaneously with currency_inserted.

Optional Feature:
- Macro CURRENCY_ESCROW_EN.
- Defined:
  - Escrow is a MAX_NOTES-deep FIFO of denomination codes.
  - REFUND emits one refund_valid per stored note, one per cycle, in insertion order, with refund_denom = code and refund_amount = that note's value. REFUND lasts note_count cycles.
- Undefined:
  - No FIFO.
  - REFUND lasts one cycle: refund_valid=1, refund_amount=total, refund_denom=0.

Test Plan:
- Reset pulse low mid-COLLECT with total=70 → all outputs 0 on the reset edge, no refund_valid, IDLE after release.
- accept_en=1; notes denom 1 then 2; confirm → note_accept ×2, total 70, currency_inserted high 2 cycles with currency_amount=70, then IDLE.
- In COLLECT: denom 6 → note_reject; total=200 then denom 3 (100) → note_reject (exceeds 255), total stays 200.
- Notes 50, 20, 10, then cancel:
  - With CURRENCY_ESCROW_EN: refunds 50, 20, 10 on consecutive cycles, denoms 2, 1, 0.
  - Without it: a single refund of 80.
- TIMEOUT=20: one note of 100, then idle 20 cycles → refund of 100, IDLE, no currency_inserted.
- Same cycle confirm=1 and cancel=1 with total=20 → REFUND (cancel wins); confirm with total=0 → stays in COLLECT.

Source files
------------

// File: rtl/currency_acceptor.sv
// currency_acceptor: validates inserted notes, holds them in escrow and either
// delivers the escrow total to atp or refunds it on cancel, timeout or
// revocation (accept_en dropping).
// Optional feature macro: CURRENCY_ESCROW_EN. When it is defined, a FIFO of
// denomination codes is kept and refunds go out note by note. When it is
// undefined, a refund is one lump-sum strobe.
module currency_acceptor #(
  parameter int MAX_TOTAL   = 255,
  parameter int MAX_NOTES   = 8,
  parameter int TIMEOUT     = 1000,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       accept_en,
  input  logic       note_valid,
  input  logic [2:0] note_denom,
  input  logic       confirm,
  input  logic       cancel,
  output logic       currency_inserted,
  output logic [7:0] currency_amount,
  output logic       note_accept,
  output logic       note_reject,
  output logic       refund_valid,
  output logic [7:0] refund_amount,
  output logic [2:0] refund_denom,
  output logic       busy,
  output logic [3:0] note_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DELIVER, REFUND} state_t;

  state_t          st;
  logic [7:0]      total;
  logic [TW-1:0]   timer;
  logic [HW-1:0]   hold;
  logic            rej_pend;

  function automatic logic [7:0] denom_val(input logic [2:0] d);
    case (d)
      3'd0:    return 8'd10;
      3'd1:    return 8'd20;
      3'd2:    return 8'd50;
      3'd3:    return 8'd100;
      3'd4:    return 8'd200;
      default: return 8'd0;
    endcase
  endfunction

`ifdef CURRENCY_ESCROW_EN
  localparam int IW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  logic [2:0] fifo [MAX_NOTES];
  logic [3:0] rd;
`endif

  logic [8:0] sum;
  logic       note_ok, do_abort, do_confirm, do_timeout, take, rej, ins_next;

  // Per-cycle COLLECT decision: cancel > revoke > confirm > note > timeout
  always_comb begin
    sum        = {1'b0, total} + {1'b0, denom_val(note_denom)};
    note_ok    = (note_denom < 3'd5) && (note_count != 4'(MAX_NOTES)) &&
                 (sum <= 9'(MAX_TOTAL));
    do_abort   = cancel || !accept_en;
    do_confirm = !do_abort && confirm && (total != 8'd0);
    do_timeout = !do_abort && !do_confirm && !note_valid && (timer == TW'(TIMEOUT));
    take       = (st == COLLECT) && !do_abort && !do_confirm && note_valid && note_ok;
    rej        = note_valid && !take;
    // A reject pulse must never overlap the delivery strobe, so it waits
    // until currency_inserted drops.
    ins_next   = ((st == COLLECT) && do_confirm) ||
                 ((st == DELIVER) && (hold != '0));
  end

  assign busy = (st != IDLE);

  // Main FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st                <= IDLE;
      total             <= '0;
      note_count        <= '0;
      timer             <= '0;
      hold              <= '0;
      rej_pend          <= 1'b0;
      currency_inserted <= 1'b0;
      currency_amount   <= '0;
      note_accept       <= 1'b0;
      note_reject       <= 1'b0;
      refund_valid      <= 1'b0;
      refund_amount     <= '0;
      refund_denom      <= '0;
`ifdef CURRENCY_ESCROW_EN
      rd                <= '0;
      for (int i = 0; i < MAX_NOTES; i++) fifo[i] <= '0;
`endif
    end else begin
      note_accept <= take;
      note_reject <= (rej | rej_pend) & ~ins_next;
      rej_pend    <= (rej | rej_pend) & ins_next;
      case (st)
        IDLE: begin
          if (accept_en) begin
            st    <= COLLECT;
            timer <= '0;
          end
        end
        COLLECT: begin
          if (note_valid)                  timer <= '0;
          else if (timer != TW'(TIMEOUT))  timer <= timer + 1'b1;
          if (do_abort || do_timeout) begin
            if (total != 8'd0) begin
              st           <= REFUND;
              refund_valid <= 1'b1;
`ifdef CURRENCY_ESCROW_EN
              refund_denom  <= fifo[0];
              refund_amount <= denom_val(fifo[0]);
              rd            <= 4'd1;
`else
              refund_denom  <= 3'd0;
              refund_amount <= total;
`endif
            end else begin
              st <= IDLE;
            end
          end else if (do_confirm) begin
            st                <= DELIVER;
            currency_inserted <= 1'b1;
            currency_amount   <= total;
            hold              <= HW'(HOLD_CYCLES - 1);
          end else if (take) begin
            total      <= sum[7:0];
            note_count <= note_count + 4'd1;
`ifdef CURRENCY_ESCROW_EN
            fifo[note_count[IW-1:0]] <= note_denom;
`endif
          end
        end
        DELIVER: begin
          if (hold == '0) begin
            st                <= IDLE;
            currency_inserted <= 1'b0;
            currency_amount   <= '0;
            total             <= '0;
            note_count        <= '0;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        REFUND: begin
`ifdef CURRENCY_ESCROW_EN
          if (rd == note_count) begin
            st            <= IDLE;
            refund_valid  <= 1'b0;
            refund_amount <= '0;
            refund_denom  <= '0;
            total         <= '0;
            note_count    <= '0;
            rd            <= '0;
          end else begin
            refund_denom  <= fifo[rd[IW-1:0]];
            refund_amount <= denom_val(fifo[rd[IW-1:0]]);
            rd            <= rd + 4'd1;
          end
`else
          st            <= IDLE;
          refund_valid  <= 1'b0;
          refund_amount <= '0;
          refund_denom  <= '0;
          total         <= '0;
          note_count    <= '0;
`endif
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
